// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment message sequencer.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
// Contents: character codes, controller state enum, code-to-segment decode.
package disp_pkg;

    // Character codes outside the 0x00-0x0F hex range
    localparam logic [4:0] CH_BLANK = 5'h10;
    localparam logic [4:0] CH_L     = 5'h11;
    localparam logic [4:0] CH_P     = 5'h12;
    localparam logic [4:0] CH_X     = 5'h13;  // drawn as an H
    localparam logic [4:0] CH_DASH  = 5'h14;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        HOLD,
        SCROLL
    } state_e;

    // Returns the active-low {g,f,e,d,c,b,a} pattern for a character code.
    // Codes 0x15-0x1F (and CH_BLANK) light nothing.
    function automatic logic [6:0] seg_pattern(input logic [4:0] code);
        logic [6:0] lit;
        case (code)
            5'h00:   lit = 7'h3F;
            5'h01:   lit = 7'h06;
            5'h02:   lit = 7'h5B;
            5'h03:   lit = 7'h4F;
            5'h04:   lit = 7'h66;
            5'h05:   lit = 7'h6D;
            5'h06:   lit = 7'h7D;
            5'h07:   lit = 7'h07;
            5'h08:   lit = 7'h7F;
            5'h09:   lit = 7'h6F;
            5'h0A:   lit = 7'h77;
            5'h0B:   lit = 7'h7C;
            5'h0C:   lit = 7'h39;
            5'h0D:   lit = 7'h5E;
            5'h0E:   lit = 7'h79;
            5'h0F:   lit = 7'h71;
            CH_L:    lit = 7'h38;
            CH_P:    lit = 7'h73;
            CH_X:    lit = 7'h76;
            CH_DASH: lit = 7'h40;
            default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver: one digit of the 8-entry window per scan slot.
// Latency: seg_o/dig_o are registered, one cycle after scan/window/blank change.
// Backpressure: none; the scan counter free-runs.
// Ports: clk_i/rst_i (sync active-high), window_i (8 char codes, [0] = leftmost),
//        blank_i (force all segments off), seg_o/dig_o (active-low pins).
module seg_scan_mux
    import disp_pkg::*;
#(
    parameter int SCAN_W = 18
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0][4:0] window_i,
    input  logic            blank_i,
    output logic [7:0]      seg_o,
    output logic [7:0]      dig_o
);

    logic [SCAN_W-1:0] scan_q;
    logic [2:0]        sel;
    logic [4:0]        code;
    logic [7:0]        seg_d;
    logic [7:0]        dig_d;
    logic [7:0]        seg_q;
    logic [7:0]        dig_q;

    assign sel = scan_q[SCAN_W-1 -: 3];

    // dig[7] is the leftmost digit, so digit s shows window entry 7-s.
    always_comb begin
        code  = window_i[3'd7 - sel];
        seg_d = blank_i ? 8'hFF : {1'b1, seg_pattern(code)};
        dig_d = ~(8'b0000_0001 << sel);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scan_q <= '0;
            seg_q  <= 8'hFF;
            dig_q  <= 8'hFF;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
            seg_q  <= seg_d;
            dig_q  <= dig_d;
        end
    end

    assign seg_o = seg_q;
    assign dig_o = dig_q;

endmodule

// File: rtl/disp_scroll_ctrl.sv
// Message sequencer: buffers up to MSG_DEPTH chars, shows them static or scrolling.
// Latency: buffer write and HOLD entry one cycle after accept; pins one cycle after window.
// Backpressure: wr_ready low outside EMPTY/LOAD and whenever flush is high.
// Ports: clk, rst (sync active-high), flush, wr_valid/wr_ready/wr_char/wr_last,
//        run, busy, pass_done, seg/dig (active-low display pins).
// Build option: define DISP_BLINK_EN to blank the display in HOLD while step MSB is set.
module disp_scroll_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_W    = 18,
    parameter int STEP_W    = 24,
    parameter int MSG_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_char,
    input  logic       wr_last,
    input  logic       run,
    output logic       busy,
    output logic       pass_done,
    output logic [7:0] seg,
    output logic [7:0] dig
);

    localparam int IDX_W = $clog2(MSG_DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(MSG_DEPTH - 1);

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  offset_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q;
    logic              pass_done_q;
    logic [4:0]        buf_q [MSG_DEPTH];

    logic              accept;
    logic [LEN_W-1:0]  wrap_off;
    logic [LEN_W:0]    pos;
    logic [7:0][4:0]   window;
    logic              blank;

    assign wr_ready = ((state_q == EMPTY) || (state_q == LOAD)) && !flush;
    assign accept   = wr_valid && wr_ready;

    // Virtual message is len chars followed by 8 blanks, so the last offset is len+7.
    // len+7 always fits in LEN_W bits because MSG_DEPTH >= 8.
    assign wrap_off = len_q + LEN_W'(7);

    // len_q is zero in EMPTY, so it doubles as the write index in both load states.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[len_q[IDX_W-1:0]] <= wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            len_q       <= '0;
            offset_q    <= '0;
            step_q      <= '0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            pass_done_q <= 1'b0;
            if (flush) begin
                state_q  <= EMPTY;
                len_q    <= '0;
                offset_q <= '0;
                step_q   <= '0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        step_q   <= '0;
                        offset_q <= '0;
                        if (accept) begin
                            len_q   <= LEN_W'(1);
                            state_q <= wr_last ? HOLD : LOAD;
                        end
                    end
                    LOAD: begin
                        step_q <= '0;
                        if (accept) begin
                            len_q <= len_q + LEN_W'(1);
                            // A full buffer ends the message even without wr_last
                            if (wr_last || (len_q == LAST_LEN)) begin
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        offset_q <= '0;
                        if (run) begin
                            state_q <= SCROLL;
                            busy_q  <= 1'b1;
                            step_q  <= '0;
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end
                    SCROLL: begin
                        step_q <= step_q + STEP_W'(1);
                        if (!run) begin
                            state_q  <= HOLD;
                            busy_q   <= 1'b0;
                            offset_q <= '0;
                        end else if (&step_q) begin
                            if (offset_q == wrap_off) begin
                                offset_q    <= '0;
                                pass_done_q <= 1'b1;
                            end else begin
                                offset_q <= offset_q + LEN_W'(1);
                            end
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    // Positions at or past len show blank; pos is one bit wider so it never wraps.
    always_comb begin
        pos    = '0;
        window = '0;
        for (int i = 0; i < 8; i++) begin
            pos = {1'b0, offset_q} + (LEN_W+1)'(i);
            if (pos < {1'b0, len_q}) begin
                window[i] = buf_q[pos[IDX_W-1:0]];
            end else begin
                window[i] = CH_BLANK;
            end
        end
    end

`ifdef DISP_BLINK_EN
    assign blank = (state_q == HOLD) && step_q[STEP_W-1];
`else
    assign blank = 1'b0;
`endif

    seg_scan_mux #(
        .SCAN_W (SCAN_W)
    ) u_scan (
        .clk_i    (clk),
        .rst_i    (rst),
        .window_i (window),
        .blank_i  (blank),
        .seg_o    (seg),
        .dig_o    (dig)
    );

    assign busy      = busy_q;
    assign pass_done = pass_done_q;

endmodule

// File: doc/disp_scroll_ctrl.md
# disp_scroll_ctrl

Message sequencer for the 8-digit seven-segment display. It accepts a character string of up to 16 entries over a valid/ready write port. It holds the string statically or scrolls it right-to-left across the eight digits at a programmable step rate. An internal scan multiplexer drives the active-low segment and digit-enable pins directly, so this block is the only thing the top level connects to the display.

## Interface
- SCAN_W, 18: scan counter width; digit select = scan[SCAN_W-1:SCAN_W-3]
- STEP_W, 24: scroll step prescaler width; one step per 2^STEP_W cycles
- MSG_DEPTH, 16: message buffer depth (power of two, ≥8)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard message, return to EMPTY (highest priority)
- wr_valid  in  1  write beat valid
- wr_ready  out  1  block accepts beat this cycle
- wr_char  in  5  character code
- wr_last  in  1  final character of message
- run  in  1  level: scroll while high
- busy  out  1  high in SCROLL
- pass_done  out  1  one-cycle pulse when a full scroll pass wraps
- seg  out  8  active-low segments, seg[7] = decimal point (always 1)
- dig  out  8  active-low digit enables, exactly one low after first scan cycle

## Operation
- Character codes: 0x00–0x0F hex digits 0–F; 0x10 blank; 0x11 L; 0x12 P; 0x13 X (H pattern); 0x14 '-'; 0x15–0x1F blank.
- States:
  - EMPTY: len=0, wr_ready=1. An accepted beat writes buf[0], len=1. If wr_last → HOLD, else → LOAD.
  - LOAD: wr_ready=1. Each accepted beat writes buf[len], len++. wr_last or len reaching MSG_DEPTH → HOLD; the 16th beat ends the message without wr_last.
  - HOLD: wr_ready=0, offset=0, static display. run=1 → SCROLL, with step counter cleared.
  - SCROLL: on each step tick (step counter all ones), offset++. Tick at offset = len+7 → offset 0, pass_done pulse. run=0 → HOLD, offset 0.
- Accept = wr_valid & wr_ready. wr_ready = (EMPTY|LOAD) & ~flush.
- Window: window[i] = buf[offset+i] if offset+i < len, else blank, for i=0..7. Virtual length is len+8 (message followed by 8 blanks).
- Scan: s = scan[SCAN_W-1:SCAN_W-3]. dig bit s low; shows window[7-s]. dig[7] is the leftmost digit and shows window[0].
- flush from any state → EMPTY next cycle. Any concurrent beat is dropped and the display goes blank.
- run high while in EMPTY/LOAD is ignored. If run is high on entering HOLD, move to SCROLL the following cycle.
- Arithmetic: offset and len are 5 bits. offset+i computed 6-bit, no wrap.

## Timing
- Reset values: state EMPTY, len 0, offset 0, scan 0, step 0, seg 8'hFF, dig 8'hFF, busy 0, pass_done 0, wr_ready 1.
- seg and dig are registered: one cycle from scan/window change to pins.
- The scan counter free-runs in all states, with each digit held for 2^(SCAN_W-3) cycles.
- The step counter free-runs in HOLD and SCROLL and is cleared on entering SCROLL. The first tick comes 2^STEP_W cycles after entry.
- pass_done is asserted in the cycle after the wrapping tick, for exactly 1 cycle.
- The buffer write lands in the cycle after the accept. HOLD is entered in the cycle after the last accept.

## Configuration
- DISP_BLINK_EN defined: in HOLD, all digits are blank (seg=8'hFF) while step counter MSB=1. dig scanning continues.
- DISP_BLINK_EN undefined: HOLD display is steady. SCROLL is unaffected in both cases.

## Structure
- Package disp_pkg holds:
  - character code constants
  - state enum (EMPTY, LOAD, HOLD, SCROLL)
  - 5-bit-code to 7-bit active-low segment pattern function
- Sub-module seg_scan_mux contains:
  - the scan counter
  - digit select
  - the window-to-pattern decode
  - the seg/dig output registers
- The controller holds the FSM, buffer, len, offset and step counter. It passes the 8-entry window to seg_scan_mux.

## Test plan
- Reset: rst high for 2 cycles → seg=FF, dig=FF, wr_ready=1, busy=0, pass_done=0.
- Load C,P,E,1 (0x0C,0x12,0x0E,0x01), wr_last on 4th → HOLD and wr_ready=0. The display shows:
  - C on dig[7]
  - P on dig[6]
  - E on dig[5]
  - 1 on dig[4]
  - blank on dig[3:0]
- Same message, SCAN_W=6, STEP_W=4, run=1 → after 16 cycles dig[7] shows P. pass_done pulses once after 12 ticks (192 cycles) and offset returns to 0.
- Present 17 beats without wr_last → 16 accepted, wr_ready low after the 16th, 17th beat stalls. State is HOLD.
- During SCROLL, assert flush with wr_valid=1 → EMPTY next cycle, len=0, no write, all digits blank, busy=0.
- DISP_BLINK_EN defined, HOLD, STEP_W=4 → seg=FF during cycles where step[3]=1, pattern shown otherwise. Undefined → pattern is steady.
